// File: rtl/needs_pkg.sv
// Shared definitions for the need-level engine: level widths, action codes,
// FSM state encoding and the saturating level arithmetic.
package needs_pkg;

  localparam int LEVEL_W   = 4;
  localparam int LEVEL_MAX = 15;

  localparam int NEED_N       = 5;
  localparam int NEED_HUNGER  = 0;
  localparam int NEED_HAPPY   = 1;
  localparam int NEED_HEALTH  = 2;
  localparam int NEED_HYGIENE = 3;
  localparam int NEED_ENERGY  = 4;

  localparam logic [2:0] ACT_FEED     = 3'd0;
  localparam logic [2:0] ACT_PLAY     = 3'd1;
  localparam logic [2:0] ACT_MEDICINE = 3'd2;
  localparam logic [2:0] ACT_CLEAN    = 3'd3;
  localparam logic [2:0] ACT_SLEEP    = 3'd4;

  typedef enum logic [1:0] {
    ST_AWAKE    = 2'd0,
    ST_SLEEPING = 2'd1,
    ST_DEAD     = 2'd2
  } state_t;

  // Clamp a signed level+inc-dec sum into 0..LEVEL_MAX.
  function automatic logic [LEVEL_W-1:0] clamp_level(input logic signed [LEVEL_W+1:0] v);
    logic signed [LEVEL_W+1:0] top;
    top = (LEVEL_W+2)'(LEVEL_MAX);
    if (v[LEVEL_W+1])
      return '0;
    else if (v > top)
      return LEVEL_W'(LEVEL_MAX);
    else
      return v[LEVEL_W-1:0];
  endfunction

endpackage

// File: rtl/need_channel.sv
// One need: a tick-driven decay timer feeding a saturating 0..15 level register
// that also takes external increments, decrements and a clear.
module need_channel
  import needs_pkg::*;
#(
  parameter int PERIOD = 10,
  parameter int INIT   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               timer_en,
  input  logic               hold,
  input  logic               inc,
  input  logic [LEVEL_W-1:0] dec,
  input  logic               clear,
  output logic [LEVEL_W-1:0] level,
  output logic               is_max
);

  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD - 1);

  logic [TW-1:0]             timer_reg;
  logic [LEVEL_W-1:0]        level_reg;
  logic                      decay_inc;
  logic [1:0]                inc_total;
  logic signed [LEVEL_W+1:0] sum;
  logic [LEVEL_W-1:0]        level_next;

  assign decay_inc = tick && timer_en && !hold && (timer_reg == TIMER_LAST);
  // Decay plus an external increment never exceeds 2, so no extra cap is needed.
  assign inc_total = {1'b0, decay_inc} + {1'b0, inc};

  always_comb begin
    sum = $signed({2'b00, level_reg})
        + $signed({{LEVEL_W{1'b0}}, inc_total})
        - $signed({2'b00, dec});
    level_next = clear ? '0 : clamp_level(sum);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_reg <= '0;
      level_reg <= LEVEL_W'(INIT);
    end else if (!hold) begin
      if (tick && timer_en)
        timer_reg <= decay_inc ? '0 : timer_reg + 1'b1;
      level_reg <= level_next;
    end
  end

  assign level  = level_reg;
  assign is_max = (level_reg == LEVEL_W'(LEVEL_MAX));

endmodule

// File: rtl/needs_engine.sv
// Pet need engine: game-tick prescaler, AWAKE/SLEEPING/DEAD state machine,
// sleep counter and action decode driving five need channels.
module needs_engine
  import needs_pkg::*;
#(
  parameter int TICK_DIV      = 50000000,
  parameter int HUNGER_TICKS  = 10,
  parameter int HAPPY_TICKS   = 15,
  parameter int HEALTH_TICKS  = 30,
  parameter int HYGIENE_TICKS = 20,
  parameter int ENERGY_TICKS  = 12,
  parameter int RELIEF        = 4,
  parameter int SLEEP_TICKS   = 8,
  parameter int INIT_LEVEL    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               action_valid,
  input  logic [2:0]         action_code,
  output logic               action_ready,
  output logic [LEVEL_W-1:0] hunger,
  output logic [LEVEL_W-1:0] happiness,
  output logic [LEVEL_W-1:0] health,
  output logic [LEVEL_W-1:0] hygiene,
  output logic [LEVEL_W-1:0] energy,
  output logic               tick,
  output logic               sleeping,
  output logic               dead
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam int SW = $clog2(SLEEP_TICKS + 1);
  localparam logic [SW-1:0] SLEEP_LOAD = SW'(SLEEP_TICKS);
  localparam logic [LEVEL_W-1:0] RELIEF_AMT = LEVEL_W'(RELIEF);

  state_t             state_reg;
  logic [PW-1:0]      presc_reg;
  logic [SW-1:0]      sleep_cnt_reg;
  logic               ready_reg;
  logic               sleeping_reg;
  logic               dead_reg;

  logic               tick_w;
  logic               accept;
  logic               any_max;
  logic               go_dead;
  logic               hold;
  logic [NEED_N-1:0]  inc_v;
  logic [NEED_N-1:0]  clr_v;
  logic [NEED_N-1:0]  ten_v;
  logic [NEED_N-1:0]  max_v;
  logic [LEVEL_W-1:0] dec_v   [NEED_N];
  logic [LEVEL_W-1:0] level_v [NEED_N];

  assign tick_w  = (presc_reg == PRESC_LAST) && (state_reg != ST_DEAD);
  assign accept  = action_valid && ready_reg;
  assign any_max = |max_v;
  assign go_dead = any_max || (state_reg == ST_DEAD);
  assign hold    = (state_reg == ST_DEAD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_AWAKE;
      presc_reg     <= '0;
      sleep_cnt_reg <= '0;
      ready_reg     <= 1'b1;
      sleeping_reg  <= 1'b0;
      dead_reg      <= 1'b0;
    end else begin
      // Parking the prescaler at 0 on the way into DEAD keeps tick quiet there.
      if (go_dead || presc_reg == PRESC_LAST)
        presc_reg <= '0;
      else
        presc_reg <= presc_reg + 1'b1;

      if (any_max) begin
        state_reg    <= ST_DEAD;
        ready_reg    <= 1'b0;
        sleeping_reg <= 1'b0;
        dead_reg     <= 1'b1;
      end else begin
        case (state_reg)
          ST_AWAKE: begin
            if (accept && action_code == ACT_SLEEP) begin
              state_reg     <= ST_SLEEPING;
              sleep_cnt_reg <= SLEEP_LOAD;
              ready_reg     <= 1'b0;
              sleeping_reg  <= 1'b1;
            end
          end
          ST_SLEEPING: begin
            if (tick_w) begin
              sleep_cnt_reg <= sleep_cnt_reg - 1'b1;
              if (sleep_cnt_reg == SW'(1)) begin
                state_reg    <= ST_AWAKE;
                ready_reg    <= 1'b1;
                sleeping_reg <= 1'b0;
              end
            end
          end
          ST_DEAD: begin
            state_reg <= ST_DEAD;
          end
          default: begin
            state_reg    <= ST_AWAKE;
            ready_reg    <= 1'b1;
            sleeping_reg <= 1'b0;
            dead_reg     <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    inc_v = '0;
    clr_v = '0;
    for (int i = 0; i < NEED_N; i++)
      dec_v[i] = '0;
    ten_v = {NEED_N{state_reg != ST_DEAD}};
    ten_v[NEED_ENERGY] = (state_reg == ST_AWAKE);
    if (accept) begin
      case (action_code)
        ACT_FEED:     dec_v[NEED_HUNGER] = RELIEF_AMT;
        ACT_PLAY: begin
          dec_v[NEED_HAPPY]  = RELIEF_AMT;
          inc_v[NEED_ENERGY] = 1'b1;
        end
        ACT_MEDICINE: dec_v[NEED_HEALTH] = RELIEF_AMT;
        ACT_CLEAN:    clr_v[NEED_HYGIENE] = 1'b1;
        default: ;
      endcase
    end
    // Sleep recovers energy one step per tick instead of letting it decay.
    if (state_reg == ST_SLEEPING && tick_w)
      dec_v[NEED_ENERGY] = LEVEL_W'(1);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NEED_N; gi++) begin : g_need
      localparam int PERIOD = (gi == NEED_HUNGER)  ? HUNGER_TICKS  :
                              (gi == NEED_HAPPY)   ? HAPPY_TICKS   :
                              (gi == NEED_HEALTH)  ? HEALTH_TICKS  :
                              (gi == NEED_HYGIENE) ? HYGIENE_TICKS : ENERGY_TICKS;
      need_channel #(
        .PERIOD (PERIOD),
        .INIT   (INIT_LEVEL)
      ) u_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick_w),
        .timer_en (ten_v[gi]),
        .hold     (hold),
        .inc      (inc_v[gi]),
        .dec      (dec_v[gi]),
        .clear    (clr_v[gi]),
        .level    (level_v[gi]),
        .is_max   (max_v[gi])
      );
    end
  endgenerate

  assign hunger       = level_v[NEED_HUNGER];
  assign happiness    = level_v[NEED_HAPPY];
  assign health       = level_v[NEED_HEALTH];
  assign hygiene      = level_v[NEED_HYGIENE];
  assign energy       = level_v[NEED_ENERGY];
  assign tick         = tick_w;
  assign action_ready = ready_reg;
  assign sleeping     = sleeping_reg;
  assign dead         = dead_reg;

endmodule

// File: tb/tb_needs_engine.sv
// Bench for needs_engine: a hand-computed vector table after reset, directed
// corner sequences, then random actions checked against a behavioural model.
module tb_needs_engine;
  import needs_pkg::*;

  localparam int TD     = 4;
  localparam int RELIEF = 4;
  localparam int SLEEP  = 8;
  localparam int INIT   = 4;
  localparam int PER [5] = '{2, 15, 30, 20, 12};
  localparam int MA = 0, MS = 1, MD = 2;

  logic       clk;
  logic       rst_n;
  logic       action_valid;
  logic [2:0] action_code;
  logic       action_ready;
  logic [3:0] hunger, happiness, health, hygiene, energy;
  logic       tick, sleeping, dead;

  needs_engine #(
    .TICK_DIV     (TD),
    .HUNGER_TICKS (2),
    .INIT_LEVEL   (INIT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .action_valid (action_valid),
    .action_code  (action_code),
    .action_ready (action_ready),
    .hunger       (hunger),
    .happiness    (happiness),
    .health       (health),
    .hygiene      (hygiene),
    .energy       (energy),
    .tick         (tick),
    .sleeping     (sleeping),
    .dead         (dead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_err;
  int m_lvl [5];
  int m_tmr [5];
  int m_presc, m_state, m_sleep;
  int snap [5];

  typedef struct {
    logic       v;
    logic [2:0] code;
    int         e_hunger;
    int         e_tick;
    int         e_rest;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dut_lvl(input int i);
    case (i)
      0: return int'(hunger);
      1: return int'(happiness);
      2: return int'(health);
      3: return int'(hygiene);
      default: return int'(energy);
    endcase
  endfunction

  function automatic bit m_tick();
    return (m_state != MD) && (m_presc == TD - 1);
  endfunction

  function automatic int clamp15(input int x);
    return (x < 0) ? 0 : ((x > 15) ? 15 : x);
  endfunction

  // Model advances one clock using the rules: ticks every TD cycles, each need
  // rises every PER ticks, actions apply relief, sleep lasts SLEEP ticks.
  task automatic model_step(input logic v, input logic [2:0] c, input logic rst);
    int inc [5];
    int dec [5];
    bit tk, acc, anymax, clr;
    if (rst) begin
      m_presc = 0; m_state = MA; m_sleep = 0;
      for (int i = 0; i < 5; i++) begin m_lvl[i] = INIT; m_tmr[i] = 0; end
      return;
    end
    tk = m_tick(); acc = v && (m_state == MA); anymax = 0; clr = 0;
    for (int i = 0; i < 5; i++) begin
      inc[i] = 0; dec[i] = 0;
      if (m_lvl[i] == 15) anymax = 1;
      if (tk && (i != 4 || m_state == MA)) begin
        m_tmr[i]++;
        if (m_tmr[i] == PER[i]) begin m_tmr[i] = 0; inc[i] = 1; end
      end
    end
    if (tk && m_state == MS) dec[4] = 1;
    if (acc) begin
      case (c)
        3'd0: dec[0] = RELIEF;
        3'd1: begin dec[1] = RELIEF; inc[4] = inc[4] + 1; end
        3'd2: dec[2] = RELIEF;
        3'd3: clr = 1;
        default: ;
      endcase
    end
    for (int i = 0; i < 5; i++) m_lvl[i] = clamp15(m_lvl[i] + inc[i] - dec[i]);
    if (clr) m_lvl[3] = 0;
    if (anymax) m_state = MD;
    else if (m_state == MA && acc && c == 3'd4) begin m_state = MS; m_sleep = SLEEP; end
    else if (m_state == MS && tk) begin
      m_sleep--;
      if (m_sleep == 0) m_state = MA;
    end
    m_presc = (m_state == MD) ? 0 : (m_presc + 1) % TD;
  endtask

  task automatic check_model();
    chk("hunger",    8'(hunger),       8'(m_lvl[0]));
    chk("happiness", 8'(happiness),    8'(m_lvl[1]));
    chk("health",    8'(health),       8'(m_lvl[2]));
    chk("hygiene",   8'(hygiene),      8'(m_lvl[3]));
    chk("energy",    8'(energy),       8'(m_lvl[4]));
    chk("tick",      8'(tick),         8'(m_tick()));
    chk("ready",     8'(action_ready), 8'(m_state == MA));
    chk("sleeping",  8'(sleeping),     8'(m_state == MS));
    chk("dead",      8'(dead),         8'(m_state == MD));
  endtask

  task automatic pre(input logic v, input logic [2:0] c, input logic rst);
    action_valid = v;
    action_code  = c;
    rst_n        = ~rst;
    @(negedge clk);
  endtask

  task automatic post(input logic v, input logic [2:0] c, input logic rst, input bit chkm);
    if (chkm && !rst) check_model();
    if (!rst && v && m_state == MA)
      $display("txn t=%0t code=%0d accepted levels=%0d/%0d/%0d/%0d/%0d",
               $time, c, m_lvl[0], m_lvl[1], m_lvl[2], m_lvl[3], m_lvl[4]);
    model_step(v, c, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [2:0] c, input logic rst);
    pre(v, c, rst);
    post(v, c, rst, 1'b1);
  endtask

  function automatic logic [3:0] care();
    if (m_state != MA)   return 4'b0;
    if (m_lvl[0] >= 9)   return {1'b1, ACT_FEED};
    if (m_lvl[4] >= 11)  return {1'b1, ACT_SLEEP};
    if (m_lvl[1] >= 10)  return {1'b1, ACT_PLAY};
    if (m_lvl[2] >= 10)  return {1'b1, ACT_MEDICINE};
    return 4'b0;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n, ticks, mx, dead_cnt;
    logic [3:0] ac;
    logic rst_r;
    n_cmp = 0; n_err = 0;

    for (int k = 0; k < 13; k++) begin
      tbl[k].v = 1'b0; tbl[k].code = 3'd0;
      tbl[k].e_hunger = (k < 8) ? 4 : ((k < 10) ? 5 : 1);
      tbl[k].e_tick = ((k % 4) == 3) ? 1 : 0;
      tbl[k].e_rest = 4;
    end
    tbl[9].v = 1'b1; tbl[9].code = ACT_FEED;

    for (int k = 0; k < 2; k++) begin pre(0, 0, 1); post(0, 0, 1, 0); end

    // Reset state, first tick on cycle 4, hunger decay at the second tick, feed.
    for (int k = 0; k < 13; k++) begin
      pre(tbl[k].v, tbl[k].code, 0);
      chk("tbl_hunger",  8'(hunger),       8'(tbl[k].e_hunger));
      chk("tbl_tick",    8'(tick),         8'(tbl[k].e_tick));
      chk("tbl_ready",   8'(action_ready), 8'(1));
      chk("tbl_happy",   8'(happiness),    8'(tbl[k].e_rest));
      chk("tbl_energy",  8'(energy),       8'(tbl[k].e_rest));
      chk("tbl_hygiene", 8'(hygiene),      8'(tbl[k].e_rest));
      chk("tbl_dead",    8'(dead | sleeping), 8'(0));
      post(tbl[k].v, tbl[k].code, 0, 1);
    end

    // Feed that would go below zero saturates at 0.
    n = 0;
    while (m_lvl[0] != 2 && n < 100) begin cyc(0, 0, 0); n++; end
    chk("reach_hunger2", 8'(m_lvl[0] == 2), 8'(1));
    cyc(1, ACT_FEED, 0);
    pre(0, 0, 0); chk("feed_floor", 8'(hunger), 8'(0)); post(0, 0, 0, 1);

    // Feed coinciding with a hunger decay step: 14 + 1 - 4.
    n = 0;
    while (!(m_state == MA && m_lvl[0] == 14 && m_tick() && m_tmr[0] == PER[0] - 1) && n < 300) begin
      cyc(0, 0, 0); n++;
    end
    chk("reach_hunger14", 8'(n < 300), 8'(1));
    cyc(1, ACT_FEED, 0);
    pre(0, 0, 0); chk("feed_with_decay", 8'(hunger), 8'(11)); post(0, 0, 0, 1);

    // Sleep from energy 10 lasts exactly SLEEP ticks and ends at energy 2.
    n = 0;
    while (!(m_state == MA && m_lvl[4] == 10 && !(m_tick() && m_tmr[4] == PER[4] - 1)
             && m_lvl[0] <= 8 && m_lvl[1] <= 12 && m_lvl[2] <= 12 && m_lvl[3] <= 12) && n < 800) begin
      ac = care(); cyc(ac[3], ac[2:0], 0); n++;
    end
    chk("reach_energy10", 8'(n < 800), 8'(1));
    cyc(1, ACT_SLEEP, 0);
    n = 0; ticks = 0;
    while (m_state == MS && n < 60) begin
      pre(1, ACT_FEED, 0);
      chk("sleep_flag", 8'(sleeping), 8'(1));
      chk("sleep_ready", 8'(action_ready), 8'(0));
      if (tick) ticks++;
      post(1, ACT_FEED, 0, 1);
      n++;
    end
    chk("sleep_ticks", 8'(ticks), 8'(SLEEP));
    pre(0, 0, 0);
    chk("wake_energy", 8'(energy), 8'(2));
    chk("wake_ready", 8'(action_ready), 8'(1));
    chk("wake_sleeping", 8'(sleeping), 8'(0));
    post(0, 0, 0, 1);

    // Death by neglect, frozen levels under constant requests, then reset.
    n = 0;
    while (m_state != MD && n < 400) begin cyc(0, 0, 0); n++; end
    chk("reach_dead", 8'(m_state == MD), 8'(1));
    for (int i = 0; i < 5; i++) snap[i] = m_lvl[i];
    mx = 0;
    for (int i = 0; i < 5; i++) if (snap[i] > mx) mx = snap[i];
    chk("dead_max_level", 8'(mx), 8'(15));
    for (int k = 0; k < 50; k++) begin
      pre(1, 3'($urandom_range(0, 7)), 0);
      chk("dead_flag", 8'(dead), 8'(1));
      chk("dead_ready", 8'(action_ready), 8'(0));
      for (int i = 0; i < 5; i++) chk("dead_frozen", 8'(dut_lvl(i)), 8'(snap[i]));
      post(action_valid, action_code, 0, 1);
    end
    pre(0, 0, 1); post(0, 0, 1, 0);
    pre(0, 0, 0);
    for (int i = 0; i < 5; i++) chk("revive_level", 8'(dut_lvl(i)), 8'(INIT));
    chk("revive_dead", 8'(dead), 8'(0));
    chk("revive_ready", 8'(action_ready), 8'(1));
    chk("revive_sleeping", 8'(sleeping), 8'(0));
    post(0, 0, 0, 1);

    // Clean in the same cycle as a hygiene decay step wins.
    n = 0;
    while (!(m_state == MA && m_lvl[3] >= 9 && m_tick() && m_tmr[3] == PER[3] - 1) && n < 1500) begin
      ac = care(); cyc(ac[3], ac[2:0], 0); n++;
    end
    chk("reach_hygiene9", 8'(n < 1500), 8'(1));
    cyc(1, ACT_CLEAN, 0);
    pre(0, 0, 0); chk("clean_over_decay", 8'(hygiene), 8'(0)); post(0, 0, 0, 1);

    // Reserved code is accepted and changes nothing.
    n = 0;
    while (!(m_state == MA && !m_tick()) && n < 10) begin cyc(0, 0, 0); n++; end
    for (int i = 0; i < 5; i++) snap[i] = m_lvl[i];
    pre(1, 3'd6, 0);
    chk("reserved_ready", 8'(action_ready), 8'(1));
    post(1, 3'd6, 0, 1);
    pre(0, 0, 0);
    for (int i = 0; i < 5; i++) chk("reserved_nochange", 8'(dut_lvl(i)), 8'(snap[i]));
    chk("reserved_awake", 8'(action_ready), 8'(1));
    post(0, 0, 0, 1);

    // Random actions, resets mid-sleep and out of DEAD, against the model.
    cyc(0, 0, 1);
    dead_cnt = 0;
    for (int k = 0; k < 1500; k++) begin
      rst_r = (m_state == MD && dead_cnt >= 3) || ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 1) == 1) ac = care();
      else ac = 4'($urandom_range(0, 15));
      cyc(ac[3], ac[2:0], rst_r);
      dead_cnt = (m_state == MD) ? dead_cnt + 1 : 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/needs_engine.md
Name: needs_engine

Overview:
- Generates the five 4-bit need levels (hunger, happiness, health, hygiene, energy) that feed the status/state-evaluation stage directly downstream.
- Levels rise over time via per-need decay timers driven by a game-tick prescaler; player actions lower them through a valid/ready handshake.
- Convention: 0 = fully satisfied, 15 = critical/dead. Contains a small AWAKE/SLEEPING/DEAD state machine.

Parameters:
- TICK_DIV, 50000000, clk cycles per game tick (1 s at 50 MHz); minimum 2.
- HUNGER_TICKS, 10, ticks per +1 hunger.
- HAPPY_TICKS, 15, ticks per +1 happiness.
- HEALTH_TICKS, 30, ticks per +1 health.
- HYGIENE_TICKS, 20, ticks per +1 hygiene.
- ENERGY_TICKS, 12, ticks per +1 energy while AWAKE.
- RELIEF, 4, amount subtracted by feed/play/medicine.
- SLEEP_TICKS, 8, duration of SLEEPING in ticks.
- INIT_LEVEL, 4, reset value of every need.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- action_valid  in  1  action request
- action_code  in  3  0 feed, 1 play, 2 medicine, 3 clean, 4 sleep, 5-7 reserved
- action_ready  out  1  high when an action can be accepted
- hunger  out  4  hunger level
- happiness  out  4  unhappiness level
- health  out  4  sickness level
- hygiene  out  4  dirtiness level
- energy  out  4  tiredness level
- tick  out  1  one-cycle pulse per game tick
- sleeping  out  1  high in SLEEPING
- dead  out  1  high in DEAD

Behaviour:
- Reset (clk rising edge with rst_n=0): all needs = INIT_LEVEL; prescaler and decay timers = 0; state AWAKE; tick=0, sleeping=0, dead=0; action_ready=1 on the first cycle after reset.
- Prescaler: counts 0..TICK_DIV-1. tick is high for one cycle when the count wraps. The prescaler runs in AWAKE and SLEEPING and is held at 0 in DEAD.
- Decay timers: each need has a timer that increments on tick. When the timer reaches its *_TICKS-1 and a tick occurs, the timer returns to 0 and that need gets inc=1 for that cycle.
  - Energy timer runs only in AWAKE.
  - In SLEEPING, energy instead gets dec=1 on every tick; its timer is held.
- Handshake: an action is accepted in the cycle where action_valid && action_ready. The effect is visible on the outputs on the next cycle.
  - action_ready = 1 only in AWAKE.
  - Reserved codes are accepted with no effect.
- Action effects (dec applied to the target need):
  - feed: hunger dec=RELIEF.
  - play: happiness dec=RELIEF and energy inc=1 (combined with any decay inc, capped at total inc 2).
  - medicine: health dec=RELIEF.
  - clean: hygiene forced to 0; this overrides any same-cycle inc.
  - sleep: go to SLEEPING and load a sleep counter with SLEEP_TICKS.
- Arithmetic: next = clamp(level + inc - dec, 0, 15), computed in 6-bit signed. Simultaneous inc and dec on one need apply both in the same cycle.
- FSM:
  - AWAKE -> SLEEPING on an accepted sleep action.
  - SLEEPING: the sleep counter decrements on tick. Go to AWAKE on the tick that takes it to 0.
  - Any state -> DEAD when any registered need == 15, evaluated every cycle. DEAD takes priority over the sleep and wake transitions in the same cycle.
  - DEAD: all needs frozen, timers held, action_ready=0, dead=1. Only rst_n leaves DEAD.
- sleeping and dead are registered state decodes.
- Reset mid-sleep or in DEAD returns everything to reset values on the next edge, with no residual timer state.

Decomposition:
- Shared package needs_pkg:
  - action code constants (ACT_FEED..ACT_SLEEP)
  - FSM state encoding (ST_AWAKE, ST_SLEEPING, ST_DEAD)
  - LEVEL_MAX=15, LEVEL_W=4
- One sub-module, need_channel, instantiated five times. It contains:
  - the decay timer (period parameter) and its timer_en input
  - the saturating level register, with inc/dec/clear inputs
  - an is_max output
- Top level holds the prescaler, the FSM, the sleep counter, and the action decode.

Test Plan (bench overrides TICK_DIV=4, HUNGER_TICKS=2, INIT_LEVEL=4):
- Reset: hold rst_n=0 for 2 cycles then release -> all needs=4, action_ready=1, dead=0, sleeping=0. tick first pulses on cycle 4 after release.
- Decay: idle 8 cycles after reset -> hunger=5 exactly at the second tick. Other needs still 4.
- Feed saturation: hunger=2, accept feed (RELIEF=4) -> hunger=0 next cycle. Simultaneous decay tick + feed with hunger=14 -> 11.
- Sleep: energy=10, accept sleep (SLEEP_TICKS=8) -> sleeping=1 and action_ready=0 for 8 ticks. Energy=2 on wake; action_ready=1 the cycle after the last tick.
- Death: let hunger decay to 15 -> dead=1 on the next cycle and action_ready=0. With action_valid=1, all needs stay frozen for 50 cycles. Then rst_n=0 -> all needs=4, state AWAKE.
- Clean vs decay and reserved code: hygiene=9 with hygiene decay tick + clean in the same cycle -> hygiene=0. action_code=6 -> accepted, no level changes.
